fpnew_divsqrt_multi_ctrl: RTL and testbench

//  Sequencing controller for the multicycle div/sqrt datapath (fsm_start/fsm_ready/reg_enable style unit).

---
 rtl/fpnew_divsqrt_multi_ctrl.sv | 131 +++++++++++++
 tb/tb_fpnew_divsqrt_multi_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_divsqrt_multi_ctrl.sv
// Sequencing controller for the multicycle div/sqrt datapath: turns an op handshake into the
// unit start pulse and per-stage pipeline enables, and holds the result until it is taken.
//
// state | meaning
// IDLE  | no op in flight, ready to accept
// INP   | walking the op through the remaining input stages
// START | waiting for the unit to be idle, then pulsing start
// WAIT  | unit computing (first cycle blanked)
// OUT   | walking the result through the remaining output stages
// HOLD  | result valid, frozen until downstream accepts
`timescale 1ns/1ps
module fpnew_divsqrt_multi_ctrl #(
  parameter int unsigned NumInpRegs = 0,
  parameter int unsigned NumOutRegs = 0,
  parameter int unsigned TagWidth   = 1,
  localparam int unsigned NumRegs   = NumInpRegs + NumOutRegs,
  localparam int unsigned EnW       = (NumRegs > 0) ? NumRegs : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [TagWidth-1:0] in_tag_i,
  input  logic                flush_i,
  output logic                unit_start_o,
  input  logic                unit_ready_i,
  output logic [EnW-1:0]      reg_enable_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [TagWidth-1:0] out_tag_o,
  output logic                busy_o
);

  localparam int unsigned MaxRegs = (NumInpRegs > NumOutRegs) ? NumInpRegs : NumOutRegs;
  localparam int unsigned CntW    = (MaxRegs > 0) ? $clog2(MaxRegs + 1) : 1;

  typedef enum logic [2:0] {IDLE, INP, START, WAIT, OUT, HOLD} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [TagWidth-1:0] tag_q;
  logic                blank_q;
  logic                accept;
  logic                done;

  assign in_ready_o   = ~flush_i & ((state_q == IDLE) | ((state_q == HOLD) & out_ready_i));
  assign accept       = in_valid_i & in_ready_o;
  assign unit_start_o = ~flush_i & (state_q == START) & unit_ready_i;
  // The unit may still report ready in the cycle right after start, so that cycle is ignored.
  assign done         = ~flush_i & (state_q == WAIT) & ~blank_q & unit_ready_i;
  assign out_valid_o  = (state_q == HOLD);
  assign out_tag_o    = tag_q;
  assign busy_o       = (state_q != IDLE);

  always_comb begin
    reg_enable_o = '0;
    if (!flush_i) begin
      for (int i = 0; i < int'(EnW); i++) begin
        if (NumInpRegs > 0 && i == 0 && accept) reg_enable_o[i] = 1'b1;
        if (state_q == INP && i == int'(cnt_q)) reg_enable_o[i] = 1'b1;
        if (NumOutRegs > 0 && i == int'(NumInpRegs) && done) reg_enable_o[i] = 1'b1;
        if (state_q == OUT && i == int'(NumInpRegs) + int'(cnt_q)) reg_enable_o[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      blank_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blank_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (accept) begin
            tag_q <= in_tag_i;
            if (NumInpRegs > 1) begin
              state_q <= INP;
              cnt_q   <= CntW'(1);
            end else begin
              state_q <= START;
              cnt_q   <= '0;
            end
          end else if (state_q == HOLD && out_ready_i) begin
            state_q <= IDLE;
          end
        end
        INP: begin
          if (int'(cnt_q) == int'(NumInpRegs) - 1) begin
            state_q <= START;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        START: begin
          if (unit_ready_i) begin
            state_q <= WAIT;
            blank_q <= 1'b1;
          end
        end
        WAIT: begin
          blank_q <= 1'b0;
          if (done) begin
            if (NumOutRegs > 1) begin
              state_q <= OUT;
              cnt_q   <= CntW'(1);
            end else begin
              state_q <= HOLD;
            end
          end
        end
        OUT: begin
          if (int'(cnt_q) == int'(NumOutRegs) - 1) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpnew_divsqrt_multi_ctrl.sv
// Scoreboard bench: three controller configurations (1/1, 0/0, 2/2 stages), each with a small
// behavioural unit model; stimulus pushes expected tags, per-instance monitors pop and compare.
`timescale 1ns/1ps
module tb_fpnew_divsqrt_multi_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      in_valid, flush, out_ready, hold_busy;
  logic [2:0][3:0] in_tag;
  logic [2:0]      in_ready, unit_start, unit_ready, out_valid, busy;
  logic [2:0][3:0] out_tag;
  logic [1:0]      en_a;
  logic [0:0]      en_b;
  logic [3:0]      en_c;
  int              lat [3];

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q [3][$];

  fpnew_divsqrt_multi_ctrl #(.NumInpRegs(1), .NumOutRegs(1), .TagWidth(4)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .in_tag_i(in_tag[0]), .flush_i(flush[0]), .unit_start_o(unit_start[0]),
    .unit_ready_i(unit_ready[0]), .reg_enable_o(en_a), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0]), .out_tag_o(out_tag[0]), .busy_o(busy[0]));

  fpnew_divsqrt_multi_ctrl #(.NumInpRegs(0), .NumOutRegs(0), .TagWidth(4)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .in_tag_i(in_tag[1]), .flush_i(flush[1]), .unit_start_o(unit_start[1]),
    .unit_ready_i(unit_ready[1]), .reg_enable_o(en_b), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1]), .out_tag_o(out_tag[1]), .busy_o(busy[1]));

  fpnew_divsqrt_multi_ctrl #(.NumInpRegs(2), .NumOutRegs(2), .TagWidth(4)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .in_tag_i(in_tag[2]), .flush_i(flush[2]), .unit_start_o(unit_start[2]),
    .unit_ready_i(unit_ready[2]), .reg_enable_o(en_c), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready[2]), .out_tag_o(out_tag[2]), .busy_o(busy[2]));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_env
    int ucnt;
    logic [3:0] e;
    // Unit model: busy for lat cycles after each start pulse.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ucnt <= 0;
      else if (unit_start[g]) ucnt <= lat[g];
      else if (ucnt > 0) ucnt <= ucnt - 1;
    end
    assign unit_ready[g] = (ucnt == 0) && !hold_busy[g];

    always @(negedge clk) begin
      if (rst_n && out_valid[g] && out_ready[g]) begin
        if (exp_q[g].size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_out dut%0d: got tag %0h expected no result", g, out_tag[g]);
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("out_tag dut%0d", g), int'(out_tag[g]), int'(e));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Presents one op; returns in the drive phase of the cycle after acceptance.
  task automatic issue(input int d, input logic [3:0] tag, input bit push);
    cyc();
    in_valid[d] = 1'b1;
    in_tag[d]   = tag;
    samp();
    check($sformatf("accept dut%0d", d), int'(in_ready[d]), 1);
    if (push) exp_q[d].push_back(tag);
    cyc();
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, input int max);
    int n;
    n = 0;
    samp();
    while (!out_valid[d] && n < max) begin
      cyc();
      samp();
      n++;
    end
    check($sformatf("valid_timeout dut%0d", d), int'(out_valid[d]), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    in_valid = '0; flush = '0; out_ready = '0; hold_busy = '0; in_tag = '0;
    lat = '{2, 2, 2};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    samp();
    check("rst in_ready", int'(in_ready[0]), 1);
    check("rst unit_start", int'(unit_start[0]), 0);
    check("rst enable", int'(en_a), 0);
    check("rst out_valid", int'(out_valid[0]), 0);
    check("rst busy", int'(busy[0]), 0);
    check("rst out_tag", int'(out_tag[0]), 0);

    // 1/1 stages, tag 3, unit busy 5 cycles.
    out_ready[0] = 1'b1;
    lat[0] = 5;
    cyc();
    in_valid[0] = 1'b1;
    in_tag[0]   = 4'h3;
    samp();
    check("t1 accept", int'(in_ready[0]), 1);
    check("t1 en c0", int'(en_a), 1);
    exp_q[0].push_back(4'h3);
    cyc();
    in_valid[0] = 1'b0;
    samp();
    check("t1 start c1", int'(unit_start[0]), 1);
    check("t1 en c1", int'(en_a), 0);
    n = 0;
    do begin
      cyc();
      samp();
      n++;
    end while (en_a != 2'b10 && n < 20);
    check("t1 done latency", n, 6);
    cyc();
    samp();
    check("t1 out_valid", int'(out_valid[0]), 1);
    cyc();
    samp();
    check("t1 idle after", int'(busy[0]), 0);

    // Stall in HOLD, then back-to-back accept.
    out_ready[0] = 1'b0;
    lat[0] = 2;
    issue(0, 4'h7, 1'b1);
    wait_valid(0, 30);
    for (int i = 0; i < 10; i++) begin
      check("hold out_valid", int'(out_valid[0]), 1);
      check("hold out_tag", int'(out_tag[0]), 7);
      check("hold enable", int'(en_a), 0);
      check("hold in_ready", int'(in_ready[0]), 0);
      cyc();
      samp();
    end
    cyc();
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_tag[0]    = 4'h5;
    samp();
    check("b2b accept", int'(in_ready[0]), 1);
    check("b2b en", int'(en_a), 1);
    exp_q[0].push_back(4'h5);
    cyc();
    in_valid[0] = 1'b0;
    samp();
    check("b2b start", int'(unit_start[0]), 1);
    check("b2b out_valid low", int'(out_valid[0]), 0);
    wait_valid(0, 30);
    cyc();
    samp();
    check("b2b idle", int'(busy[0]), 0);

    // Flush in WAIT, then flush coincident with a valid in IDLE.
    lat[0] = 6;
    issue(0, 4'h9, 1'b0);
    samp();
    cyc();
    samp();
    cyc();
    flush[0] = 1'b1;
    samp();
    check("flush start", int'(unit_start[0]), 0);
    check("flush en", int'(en_a), 0);
    check("flush in_ready", int'(in_ready[0]), 0);
    cyc();
    flush[0] = 1'b0;
    samp();
    check("flush wait busy", int'(busy[0]), 0);
    check("flush wait valid", int'(out_valid[0]), 0);
    n = 0;
    while (!unit_ready[0] && n < 20) begin
      cyc();
      samp();
      n++;
    end
    cyc();
    flush[0]    = 1'b1;
    in_valid[0] = 1'b1;
    in_tag[0]   = 4'h1;
    samp();
    check("flush+valid in_ready", int'(in_ready[0]), 0);
    cyc();
    flush[0]    = 1'b0;
    in_valid[0] = 1'b0;
    samp();
    check("flush+valid busy", int'(busy[0]), 0);
    lat[0] = 2;
    issue(0, 4'h4, 1'b1);
    wait_valid(0, 30);

    // Flush in HOLD drops the result.
    cyc();
    out_ready[0] = 1'b0;
    issue(0, 4'hA, 1'b0);
    wait_valid(0, 30);
    cyc();
    flush[0] = 1'b1;
    samp();
    check("flush hold en", int'(en_a), 0);
    cyc();
    flush[0] = 1'b0;
    samp();
    check("flush hold valid", int'(out_valid[0]), 0);
    check("flush hold busy", int'(busy[0]), 0);
    out_ready[0] = 1'b1;
    issue(0, 4'hB, 1'b1);
    wait_valid(0, 30);

    // No pipeline stages: start held off while the unit is busy.
    out_ready[1] = 1'b1;
    hold_busy[1] = 1'b1;
    lat[1] = 3;
    cyc();
    in_valid[1] = 1'b1;
    in_tag[1]   = 4'h6;
    samp();
    check("r0 accept", int'(in_ready[1]), 1);
    check("r0 en", int'(en_b), 0);
    exp_q[1].push_back(4'h6);
    cyc();
    in_valid[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      samp();
      check("r0 start held", int'(unit_start[1]), 0);
      check("r0 busy", int'(busy[1]), 1);
      cyc();
    end
    hold_busy[1] = 1'b0;
    samp();
    check("r0 start", int'(unit_start[1]), 1);
    cyc();
    samp();
    check("r0 single pulse", int'(unit_start[1]), 0);
    wait_valid(1, 30);

    // 2/2 stages: walk enables, reset during OUT.
    out_ready[2] = 1'b1;
    issue(2, 4'hC, 1'b0);
    samp();
    check("c en inp1", int'(en_c), 4'b0010);
    cyc();
    samp();
    check("c start", int'(unit_start[2]), 1);
    check("c en start", int'(en_c), 0);
    n = 0;
    do begin
      cyc();
      samp();
      n++;
    end while (en_c != 4'b0100 && n < 20);
    check("c en done", int'(en_c), 4'b0100);
    cyc();
    samp();
    check("c en out", int'(en_c), 4'b1000);
    #1 rst_n = 1'b0;
    #1;
    check("rst mid busy", int'(busy[2]), 0);
    check("rst mid en", int'(en_c), 0);
    check("rst mid in_ready", int'(in_ready[2]), 1);
    check("rst mid out_valid", int'(out_valid[2]), 0);
    check("rst mid out_tag", int'(out_tag[2]), 0);
    cyc();
    rst_n = 1'b1;
    issue(2, 4'hD, 1'b1);
    wait_valid(2, 40);

    cyc();
    samp();
    for (int d = 0; d < 3; d++) check($sformatf("queue drained dut%0d", d), exp_q[d].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
